// File: rtl/counter_run_ctrl_pkg.sv
// Shared codes for the interval-counter run controller: counter state codes,
// command op codes and the controller FSM encoding.
package counter_run_ctrl_pkg;

    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned STATE_W_DEF = 8;
    localparam int unsigned OP_W        = 2;

    // State codes understood by the counter instance.
    localparam logic [7:0] STATE_RESET = 8'd0;
    localparam logic [7:0] STATE_RUN   = 8'd1;
    localparam logic [7:0] STATE_HALT  = 8'd2;

    typedef enum logic [OP_W-1:0] {
        OP_START  = 2'd0,
        OP_PAUSE  = 2'd1,
        OP_RESUME = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_RUN   = 2'd1,
        FSM_PAUSE = 2'd2,
        FSM_DONE  = 2'd3
    } fsm_e;

endpackage

// File: rtl/counter_run_ctrl_if.sv
// Command port, counter-side signals and status of the run controller.
// master: software side plus the counter value feeding back; slave: the controller.
interface counter_run_ctrl_if
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned STATE_W = STATE_W_DEF
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    op_e                cmd_op;
    logic [CNT_W-1:0]   cmd_data;
    logic [CNT_W-1:0]   cfg_interval;
    logic [CNT_W-1:0]   count_in;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   interval;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cfg_interval, count_in,
        input  cmd_ready, state, interval, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cfg_interval, count_in,
        output cmd_ready, state, interval, busy, done, err
    );

endinterface

// File: rtl/counter_run_ctrl.sv
// Command-driven run controller: starts, pauses, resumes and clears the
// interval counter and halts it exactly on the programmed target count.
module counter_run_ctrl
    import counter_run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    counter_run_ctrl_if.slave  bus
);

    fsm_e             fsm_q;
    fsm_e             fsm_d;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] target_d;
    logic [CNT_W-1:0] interval_q;
    logic [CNT_W-1:0] interval_d;
    logic             err_q;
    logic             err_d;
    logic             busy_q;
    logic             done_q;
    logic             accept_c;
    logic             match_c;
    logic [STATE_W-1:0] state_c;

    // Ready whenever out of reset; one command per cycle by construction.
    assign bus.cmd_ready = ~rst;
    assign accept_c      = bus.cmd_valid & ~rst;
    assign match_c       = (bus.count_in == target_q);

    // Next-state, latched operands and illegal-command detection.
    always_comb begin
        fsm_d      = fsm_q;
        target_d   = target_q;
        interval_d = interval_q;
        err_d      = 1'b0;
        case (fsm_q)
            FSM_IDLE: begin
                if (accept_c) begin
                    case (bus.cmd_op)
                        OP_START: begin
                            fsm_d      = FSM_RUN;
                            target_d   = bus.cmd_data;
                            interval_d = bus.cfg_interval;
                        end
                        OP_CLEAR: fsm_d = FSM_IDLE;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            FSM_RUN: begin
                // CLEAR beats the match; the match beats (and absorbs) PAUSE.
                if (accept_c && bus.cmd_op == OP_CLEAR) begin
                    fsm_d = FSM_IDLE;
                end else begin
                    if (match_c) begin
                        fsm_d = FSM_DONE;
                    end else if (accept_c && bus.cmd_op == OP_PAUSE) begin
                        fsm_d = FSM_PAUSE;
                    end
                    if (accept_c && (bus.cmd_op == OP_START || bus.cmd_op == OP_RESUME)) begin
                        err_d = 1'b1;
                    end
                end
            end
            FSM_PAUSE: begin
                if (accept_c) begin
                    case (bus.cmd_op)
                        OP_RESUME: fsm_d = FSM_RUN;
                        OP_CLEAR:  fsm_d = FSM_IDLE;
                        default:   err_d = 1'b1;
                    endcase
                end
            end
            FSM_DONE: begin
                if (accept_c) begin
                    if (bus.cmd_op == OP_CLEAR) begin
                        fsm_d = FSM_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: fsm_d = FSM_IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= FSM_IDLE;
            target_q   <= '0;
            interval_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            target_q   <= target_d;
            interval_q <= interval_d;
            err_q      <= err_d;
            busy_q     <= (fsm_d == FSM_RUN) || (fsm_d == FSM_PAUSE);
            done_q     <= (fsm_d == FSM_DONE);
        end
    end

    // Counter state code; HALT in the match cycle so the count never passes target.
    always_comb begin
        state_c = STATE_W'(STATE_RESET);
        if (!rst) begin
            case (fsm_q)
                FSM_RUN:   state_c = match_c ? STATE_W'(STATE_HALT) : STATE_W'(STATE_RUN);
                FSM_PAUSE: state_c = STATE_W'(STATE_HALT);
                FSM_DONE:  state_c = STATE_W'(STATE_HALT);
                default:   state_c = STATE_W'(STATE_RESET);
            endcase
        end
    end

    assign bus.state    = state_c;
    assign bus.interval = interval_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl driving a behavioural interval counter.
module tb_counter_run_ctrl;
    import counter_run_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    counter_run_ctrl_if #(.CNT_W(32), .STATE_W(8)) bus ();

    counter_run_ctrl #(.CNT_W(32), .STATE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural counter: RESET clears the count (not the prescaler phase),
    // RUN increments once every interval+1 cycles, HALT holds.
    logic [31:0] cnt_q   = '0;
    logic [31:0] phase_q = '0;
    always @(posedge clk) begin
        if (bus.state == STATE_RUN) begin
            if (phase_q >= bus.interval) begin
                cnt_q   <= cnt_q + 32'd1;
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + 32'd1;
            end
        end else if (bus.state != STATE_HALT) begin
            cnt_q <= '0;
        end
    end
    assign bus.count_in = cnt_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a command at the current negedge; returns at the negedge after acceptance.
    task automatic cmd(input op_e op, input logic [31:0] data, input logic [31:0] intv);
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_data     = data;
        bus.cfg_interval = intv;
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
    endtask

    task automatic wait_count(input logic [31:0] value, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.count_in == value) break;
            @(negedge clk);
        end
        check(tag, bus.count_in, value);
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] snap;

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = OP_START;
        bus.cmd_data     = '0;
        bus.cfg_interval = '0;

        // Reset behaviour
        idle(2);
        check("rst_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_interval", bus.interval, 32'd0);
        rst = 1'b0;
        idle(1);
        check("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_rst_state", 32'(bus.state), 32'd0);

        // Basic run to target 5 at interval 3
        cmd(OP_START, 32'd5, 32'd3);
        check("basic_busy", 32'(bus.busy), 32'd1);
        check("basic_state_run", 32'(bus.state), 32'd1);
        check("basic_interval", bus.interval, 32'd3);
        wait_done(200, "basic_done_timeout");
        check("basic_count", bus.count_in, 32'd5);
        check("basic_busy_off", 32'(bus.busy), 32'd0);
        check("basic_state_halt", 32'(bus.state), 32'd2);
        idle(50);
        check("basic_hold_count", bus.count_in, 32'd5);
        check("basic_hold_done", 32'(bus.done), 32'd1);

        // RESUME in DONE is illegal
        cmd(OP_RESUME, 32'd0, 32'd0);
        check("done_resume_err", 32'(bus.err), 32'd1);
        check("done_resume_done", 32'(bus.done), 32'd1);
        idle(1);
        check("err_pulse_end", 32'(bus.err), 32'd0);

        // CLEAR back to IDLE
        cmd(OP_CLEAR, 32'd0, 32'd0);
        check("clear_err", 32'(bus.err), 32'd0);
        check("clear_state", 32'(bus.state), 32'd0);
        check("clear_done", 32'(bus.done), 32'd0);
        idle(1);
        check("clear_count", bus.count_in, 32'd0);

        // PAUSE in IDLE is illegal and leaves the FSM alone
        cmd(OP_PAUSE, 32'd0, 32'd0);
        check("idle_pause_err", 32'(bus.err), 32'd1);
        check("idle_pause_state", 32'(bus.state), 32'd0);
        check("idle_pause_busy", 32'(bus.busy), 32'd0);

        // Pause/resume run to 20 at interval 1, with an illegal START mid-run
        cmd(OP_START, 32'd20, 32'd1);
        check("pr_state_run", 32'(bus.state), 32'd1);
        cmd(OP_START, 32'd2, 32'd0);
        check("run_start_err", 32'(bus.err), 32'd1);
        check("run_start_interval", bus.interval, 32'd1);
        wait_count(32'd4, 100, "pr_reach4");
        cmd(OP_PAUSE, 32'd0, 32'd0);
        check("pause_err", 32'(bus.err), 32'd0);
        check("pause_state", 32'(bus.state), 32'd2);
        check("pause_busy", 32'(bus.busy), 32'd1);
        snap = bus.count_in;
        check("pause_count_4or5", 32'(bus.count_in == 32'd4 || bus.count_in == 32'd5), 32'd1);
        idle(30);
        check("pause_frozen", bus.count_in, snap);
        cmd(OP_RESUME, 32'd0, 32'd0);
        check("resume_err", 32'(bus.err), 32'd0);
        wait_done(200, "pr_done_timeout");
        check("pr_count", bus.count_in, 32'd20);
        check("pr_interval", bus.interval, 32'd1);

        // Exact stop at interval 0
        cmd(OP_CLEAR, 32'd0, 32'd0);
        cmd(OP_START, 32'd7, 32'd0);
        wait_done(100, "i0_done_timeout");
        check("i0_count", bus.count_in, 32'd7);
        idle(10);
        check("i0_hold", bus.count_in, 32'd7);

        // CLEAR then START next cycle with target 0
        cmd(OP_CLEAR, 32'd0, 32'd0);
        cmd(OP_START, 32'd0, 32'd0);
        check("t0_halt_now", 32'(bus.state), 32'd2);
        check("t0_not_done_yet", 32'(bus.done), 32'd0);
        check("t0_count", bus.count_in, 32'd0);
        idle(1);
        check("t0_done", 32'(bus.done), 32'd1);
        check("t0_count_hold", bus.count_in, 32'd0);

        // CLEAR collides with the match cycle
        cmd(OP_CLEAR, 32'd0, 32'd0);
        cmd(OP_START, 32'd6, 32'd0);
        wait_count(32'd6, 100, "cc_reach6");
        check("cc_mealy_halt", 32'(bus.state), 32'd2);
        check("cc_not_done", 32'(bus.done), 32'd0);
        cmd(OP_CLEAR, 32'd0, 32'd0);
        check("cc_state", 32'(bus.state), 32'd0);
        check("cc_busy", 32'(bus.busy), 32'd0);
        idle(3);
        check("cc_never_done", 32'(bus.done), 32'd0);

        // PAUSE collides with the match cycle
        cmd(OP_START, 32'd6, 32'd0);
        wait_count(32'd6, 100, "pc_reach6");
        cmd(OP_PAUSE, 32'd0, 32'd0);
        check("pc_done", 32'(bus.done), 32'd1);
        check("pc_err", 32'(bus.err), 32'd0);
        check("pc_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a run
        cmd(OP_CLEAR, 32'd0, 32'd0);
        cmd(OP_START, 32'd50, 32'd0);
        wait_count(32'd9, 100, "mr_reach9");
        rst = 1'b1;
        #1;
        check("mr_state_in_rst", 32'(bus.state), 32'd0);
        check("mr_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        idle(1);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_done", 32'(bus.done), 32'd0);
        check("mr_interval", bus.interval, 32'd0);
        rst = 1'b0;
        idle(1);
        check("mr_idle_state", 32'(bus.state), 32'd0);
        cmd(OP_START, 32'd3, 32'd2);
        wait_done(100, "mr_restart_timeout");
        check("mr_restart_count", bus.count_in, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
